// File: rtl/fft_sequencer_pkg.sv
// Shared types and sizing for the FFT load/butterfly/drain sequencer.
package fft_sequencer_pkg;

    localparam int unsigned LOG2N   = 5;
    localparam int unsigned N       = 1 << LOG2N;
    localparam int unsigned PAIRS   = N / 2;
    localparam int unsigned W       = 16;
    localparam int unsigned STAGE_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/fft_sequencer_pair_index.sv
// Maps (stage, pair) to the in-place butterfly indices: i is the pair number with a
// zero inserted at bit stage-1, and j sets that bit.
module fft_pair_index
    import fft_sequencer_pkg::*;
#(
    parameter int unsigned LOG2N = fft_sequencer_pkg::LOG2N
) (
    input  logic [STAGE_W-1:0] stage,
    input  logic [LOG2N-2:0]   pair,
    output logic [LOG2N-1:0]   pair_i,
    output logic [LOG2N-1:0]   pair_j
);

    logic [LOG2N-1:0] sh;
    logic [LOG2N-1:0] bitv;
    logic [LOG2N-1:0] mask;
    logic [LOG2N-1:0] pw;

    always_comb begin
        sh     = (stage == '0) ? '0 : LOG2N'(stage - STAGE_W'(1));
        bitv   = LOG2N'(1) << sh;
        mask   = bitv - LOG2N'(1);
        pw     = LOG2N'(pair);
        pair_i = ((pw & ~mask) << 1) | (pw & mask);
        pair_j = pair_i | bitv;
    end

endmodule

// File: rtl/fft_sequencer.sv
// Sequences an in-place radix-2 FFT: loads N samples, issues one external butterfly
// per cycle across all stages, then drains the array in index order.
module fft_sequencer
    import fft_sequencer_pkg::*;
#(
    parameter int unsigned LOG2N = fft_sequencer_pkg::LOG2N,
    parameter int unsigned W     = fft_sequencer_pkg::W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       in_re,
    input  logic [W-1:0]       in_im,
    output logic [STAGE_W-1:0] bf_stage,
    output logic [LOG2N-1:0]   bf_i,
    output logic [LOG2N-1:0]   bf_j,
    output logic [W-1:0]       bf_xir,
    output logic [W-1:0]       bf_xic,
    output logic [W-1:0]       bf_xjr,
    output logic [W-1:0]       bf_xjc,
    input  logic [W-1:0]       bf_yir,
    input  logic [W-1:0]       bf_yic,
    input  logic [W-1:0]       bf_yjr,
    input  logic [W-1:0]       bf_yjc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       out_re,
    output logic [W-1:0]       out_im,
    output logic [LOG2N-1:0]   out_idx,
    output logic               busy,
    output logic               done
);

    localparam int unsigned NPTS   = 1 << LOG2N;
    localparam int unsigned NPAIRS = NPTS / 2;

    state_t               state, state_nxt;
    logic [LOG2N-1:0]     cnt, cnt_nxt;
    logic [STAGE_W-1:0]   stage, stage_nxt;
    logic [LOG2N-2:0]     pair, pair_nxt;
    logic                 done_nxt;
    logic [LOG2N-1:0]     pi, pj;

    logic [W-1:0] mem_re [NPTS];
    logic [W-1:0] mem_im [NPTS];

    fft_pair_index #(.LOG2N(LOG2N)) u_pair_index (
        .stage  (stage),
        .pair   (pair),
        .pair_i (pi),
        .pair_j (pj)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            stage <= '0;
            pair  <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            stage <= stage_nxt;
            pair  <= pair_nxt;
            done  <= done_nxt;
        end
    end

    // Sample array: load writes, in-place butterfly write-back; never reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == LOAD && in_valid) begin
                mem_re[cnt] <= in_re;
                mem_im[cnt] <= in_im;
            end
            if (state == RUN) begin
                mem_re[pi] <= bf_yir;
                mem_im[pi] <= bf_yic;
                mem_re[pj] <= bf_yjr;
                mem_im[pj] <= bf_yjc;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stage_nxt = stage;
        pair_nxt  = pair;
        done_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD;
                    cnt_nxt   = '0;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    cnt_nxt = cnt + LOG2N'(1);
                    if (cnt == LOG2N'(NPTS - 1)) begin
                        state_nxt = RUN;
                        stage_nxt = STAGE_W'(1);
                        pair_nxt  = '0;
                    end
                end
            end
            RUN: begin
                if (pair == (LOG2N-1)'(NPAIRS - 1)) begin
                    pair_nxt = '0;
                    if (stage == STAGE_W'(LOG2N)) begin
                        state_nxt = DRAIN;
                        stage_nxt = '0;
                        cnt_nxt   = '0;
                    end else begin
                        stage_nxt = stage + STAGE_W'(1);
                    end
                end else begin
                    pair_nxt = pair + (LOG2N-1)'(1);
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (cnt == LOG2N'(NPTS - 1)) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = cnt + LOG2N'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == LOAD);
        out_valid = (state == DRAIN);
        busy      = (state != IDLE);
        bf_stage  = (state == RUN) ? stage : '0;
        bf_i      = (state == RUN) ? pi : '0;
        bf_j      = (state == RUN) ? pj : '0;
        bf_xir    = mem_re[pi];
        bf_xic    = mem_im[pi];
        bf_xjr    = mem_re[pj];
        bf_xjc    = mem_im[pj];
        out_re    = mem_re[cnt];
        out_im    = mem_im[cnt];
        out_idx   = cnt;
    end

endmodule

// File: tb/tb_fft_sequencer.sv
// Directed bench for fft_sequencer with a stub butterfly (pass-through or i/j swap).
module tb_fft_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, in_valid, out_ready;
    logic        in_ready, out_valid, busy, done;
    logic [15:0] in_re, in_im;
    logic [2:0]  bf_stage;
    logic [4:0]  bf_i, bf_j, out_idx;
    logic [15:0] bf_xir, bf_xic, bf_xjr, bf_xjc;
    logic [15:0] bf_yir, bf_yic, bf_yjr, bf_yjc;
    logic [15:0] out_re, out_im;
    logic        swap_mode;

    logic [15:0] din_re [32];
    logic [15:0] din_im [32];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Stub butterfly: swap mode moves x[i]->j and x[j]->i, so after all five
    // stages array[k] holds the sample loaded at k^31.
    assign bf_yir = swap_mode ? bf_xjr : bf_xir;
    assign bf_yic = swap_mode ? bf_xjc : bf_xic;
    assign bf_yjr = swap_mode ? bf_xir : bf_xjr;
    assign bf_yjc = swap_mode ? bf_xic : bf_xjc;

    fft_sequencer dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
        .bf_stage(bf_stage), .bf_i(bf_i), .bf_j(bf_j),
        .bf_xir(bf_xir), .bf_xic(bf_xic), .bf_xjr(bf_xjr), .bf_xjc(bf_xjc),
        .bf_yir(bf_yir), .bf_yic(bf_yic), .bf_yjr(bf_yjr), .bf_yjc(bf_yjc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im), .out_idx(out_idx),
        .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_i(input int s, input int p);
        int r;
        r = 0;
        for (int b = 0; b < 4; b++) begin
            if (b < s - 1) r = r | (((p >> b) & 1) << b);
            else           r = r | (((p >> b) & 1) << (b + 1));
        end
        return r;
    endfunction

    task automatic idle_checks(input string tag);
        check({tag, "_busy"},  32'(busy), 0);
        check({tag, "_inrdy"}, 32'(in_ready), 0);
        check({tag, "_ovld"},  32'(out_valid), 0);
        check({tag, "_done"},  32'(done), 0);
        check({tag, "_stage"}, 32'(bf_stage), 0);
    endtask

    // Full transform driven and sampled on negedges; cyc counts posedges from the start edge.
    task automatic run_xfer(input bit vtoggle, input int stall_idx, input bit poke,
                            input bit rst_mid, input bit swap);
        int cyc, k, stalls, load_cyc, ei;
        swap_mode = swap;
        start = 1'b1;
        @(negedge clk); cyc = 1; start = 1'b0;
        check("start_busy", 32'(busy), 1);
        check("load_inrdy", 32'(in_ready), 1);
        k = 0;
        while (k < 32 && cyc < 400) begin
            in_valid = vtoggle ? (cyc % 2 == 0) : 1'b1;
            in_re = din_re[k];
            in_im = din_im[k];
            if (in_valid && in_ready) k++;
            @(negedge clk); cyc++;
        end
        check("load_count", 32'(k), 32);
        in_valid = 1'b1;
        in_re = 16'hdead;
        in_im = 16'hbeef;
        load_cyc = cyc;
        check("run_inrdy", 32'(in_ready), 0);
        for (int s = 1; s <= 5; s++) begin
            for (int p = 0; p < 16; p++) begin
                check("bf_stage", 32'(bf_stage), 32'(s));
                check("bf_i", 32'(bf_i), 32'(model_i(s, p)));
                check("bf_j", 32'(bf_j), 32'(model_i(s, p) + (1 << (s - 1))));
                if (rst_mid && s == 3 && p == 4) begin
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    idle_checks("midrst");
                    in_valid = 1'b0;
                    return;
                end
                start = poke && s == 2 && p == 3;
                @(negedge clk); cyc++;
                start = 1'b0;
            end
        end
        check("drain_ovld", 32'(out_valid), 1);
        check("drain_cyc", 32'(cyc), 32'(load_cyc + 80));
        if (!vtoggle) check("first_out_cyc", 32'(cyc), 113);
        k = 0;
        stalls = 0;
        while (k < 32 && cyc < 1000) begin
            ei = swap ? (k ^ 31) : k;
            check("out_valid", 32'(out_valid), 1);
            check("out_idx", 32'(out_idx), 32'(k));
            check("out_re", 32'(out_re), 32'(din_re[ei]));
            check("out_im", 32'(out_im), 32'(din_im[ei]));
            if (k == stall_idx && stalls < 3) begin
                out_ready = 1'b0;
                stalls++;
            end else begin
                out_ready = 1'b1;
            end
            start = poke && k == 10;
            if (out_ready) k++;
            @(negedge clk); cyc++;
            start = 1'b0;
        end
        out_ready = 1'b1;
        check("done_pulse", 32'(done), 1);
        check("done_busy", 32'(busy), 0);
        check("done_ovld", 32'(out_valid), 0);
        check("done_cyc", 32'(cyc), 32'(load_cyc + 80 + 32 + stalls));
        if (!vtoggle && stalls == 0) check("done_cyc_abs", 32'(cyc), 145);
        @(negedge clk);
        check("done_once", 32'(done), 0);
        if (poke) begin
            repeat (4) begin
                @(negedge clk);
                check("poke_idle", 32'(busy), 0);
                check("poke_nodone", 32'(done), 0);
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_re = '0; in_im = '0; swap_mode = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle_checks("reset");

        // rst together with start keeps the block idle
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        idle_checks("rst_start");

        // all-zero input
        for (int k = 0; k < 32; k++) begin din_re[k] = '0; din_im[k] = '0; end
        run_xfer(1'b0, -1, 1'b0, 1'b0, 1'b0);

        // ramp, pass-through stub
        for (int k = 0; k < 32; k++) begin din_re[k] = 16'(k); din_im[k] = '0; end
        run_xfer(1'b0, -1, 1'b0, 1'b0, 1'b0);

        // throttled input, swap stub, sign bits set
        for (int k = 0; k < 32; k++) begin
            din_re[k] = 16'(k * 3 + 100);
            din_im[k] = 16'h8000 | 16'(k);
        end
        run_xfer(1'b1, -1, 1'b0, 1'b0, 1'b1);

        // output stall at index 7
        for (int k = 0; k < 32; k++) begin
            din_re[k] = 16'($urandom);
            din_im[k] = 16'($urandom);
        end
        run_xfer(1'b0, 7, 1'b0, 1'b0, 1'b1);

        // reset mid-RUN, then a clean transform
        run_xfer(1'b0, -1, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 32; k++) begin
            din_re[k] = 16'hffff - 16'(k);
            din_im[k] = 16'(k << 8);
        end
        run_xfer(1'b0, -1, 1'b0, 1'b0, 1'b1);

        // start pokes during RUN and DRAIN are ignored
        run_xfer(1'b0, -1, 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fft_sequencer.md
FFT_SEQUENCER -- requirements
Module: fft_sequencer

Interface
REQ-001 SHALL have parameter LOG2N, default 5; transform-size exponent (N = 32 points, 5 stages).
REQ-002 SHALL have parameter W, default 16; sample width in sign-magnitude (bit W-1 = sign).
REQ-003 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  in  1  synchronous active-high reset.
REQ-005 SHALL have port start  in  1  one-cycle request to begin a transform.
REQ-006 SHALL have port in_valid  in  1  input sample offered.
REQ-007 SHALL have port in_ready  out  1  sequencer accepts input sample.
REQ-008 SHALL have ports in_re, in_im  in  W each  input sample, real and imaginary parts.
REQ-009 SHALL have ports bf_stage (out, 3), bf_i (out, 5), bf_j (out, 5)  butterfly stage and pair indices.
REQ-010 SHALL have ports bf_xir, bf_xic, bf_xjr, bf_xjc  out  W each  butterfly operands.
REQ-011 SHALL have ports bf_yir, bf_yic, bf_yjr, bf_yjc  in  W each  butterfly results (combinational, same cycle).
REQ-012 SHALL have port out_valid  out  1  output sample presented.
REQ-013 SHALL have port out_ready  in  1  downstream accepts output sample.
REQ-014 SHALL have ports out_re, out_im (out, W each), out_idx (out, 5)  output sample and its array index.
REQ-015 SHALL have ports busy (out, 1), high whenever state is not IDLE, and done (out, 1), a one-cycle completion pulse.

Function
REQ-016 SHALL implement states IDLE, LOAD, RUN, DRAIN and hold a 32-entry complex sample array (re and im, W bits each).
REQ-017 IDLE: start=1 SHALL move to LOAD at the next edge and clear the load counter; start is ignored in all other states.
REQ-018 LOAD: in_ready=1; each cycle with in_valid&in_ready SHALL write in_re/in_im to array[cnt] and increment cnt; accepting cnt=31 SHALL move to RUN with stage=1 and pair=0.
REQ-019 RUN: exactly one butterfly per cycle, 16 pairs per stage, stages 1..5 in order, 80 cycles total with no stalls.
REQ-020 Pair mapping: for stage s and pair p (0..15), i SHALL be p with a 0 inserted at bit position s-1, and j = i + 2^(s-1).
REQ-021 RUN: bf_x* SHALL come combinationally from array[i] and array[j]; bf_y* SHALL be written in place to array[i] (yir/yic) and array[j] (yjr/yjc) at the same edge.
REQ-022 The last pair of stage 5 SHALL move to DRAIN with cnt=0; bf_stage, bf_i and bf_j SHALL be 0 outside RUN.
REQ-023 DRAIN: out_valid=1; out_re, out_im and out_idx SHALL present array[cnt] and cnt; cnt advances only on out_valid&out_ready; out_ready=0 SHALL hold all outputs stable.
REQ-024 Acceptance at cnt=31 SHALL return the block to IDLE and assert done for exactly that next cycle.
REQ-025 The sequencer SHALL perform no arithmetic; sample bits SHALL pass unmodified, with no output reordering (array index order).
REQ-026 in_ready SHALL be 0 outside LOAD and out_valid SHALL be 0 outside DRAIN; in_valid outside LOAD is ignored.
REQ-027 Latency from start to the first out_valid SHALL be 1 + 32 + 80 cycles when in_valid is held high.

Reset
REQ-028 rst SHALL force IDLE, counters, stage and pair to 0, and busy, done, in_ready and out_valid to 0 at the next edge, including mid-LOAD, mid-RUN and mid-DRAIN.
REQ-029 Array contents are not cleared by rst; out_re and out_im are don't-care while out_valid=0.
REQ-030 rst asserted together with start SHALL win; the block remains in IDLE.

Structure
REQ-031 A shared package SHALL hold the state enum, LOG2N, N = 2^LOG2N, PAIRS = N/2, and W.
REQ-032 The pair-index generator (s, p -> i, j) SHALL be the one sub-module, fft_pair_index, and is combinational.
REQ-033 The butterfly SHALL be instantiated outside this block and connected through the bf_* ports.

Verification
REQ-034 All-zero input, start, in_valid=1, out_ready=1 -> first out_valid at cycle 113; 32 zero outputs; done at cycle 145.
REQ-035 Pass-through stub butterfly (y = x), input re=k, im=0 -> outputs re=k in index order; bf_i/bf_j follow REQ-020 (for example s=3, p=5 -> i=9, j=13).
REQ-036 in_valid toggled every other cycle -> array contents match the accepted samples in order; RUN starts one cycle after the 32nd accept.
REQ-037 out_ready low for 3 cycles at cnt=7 -> out_idx=7 held with stable data; no index skipped or repeated.
REQ-038 rst pulsed at RUN stage 3, pair 4 -> IDLE next cycle, busy=0; a new start runs a full, correct transform.
REQ-039 start pulsed during RUN and DRAIN -> ignored; the cycle count is unchanged and exactly one done pulse occurs.
